// File: rtl/spi_flash_responder.sv
// SPI mode-0 responder that behaves like a small serial NOR flash.
// SPI pins are asynchronous to clk; the backing store is an internal byte RAM.
module spi_flash_responder #(
    parameter int          ADDR_W      = 10,
    parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
    parameter int          BUSY_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       spi_sck,
    input  logic       spi_csn,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic       wel,
    output logic       wip,
    output logic [7:0] last_cmd
);
    // state   | meaning
    // IDLE    | chip select high
    // CMD     | receiving opcode
    // ADDR    | receiving 3 address bytes, MSB first
    // RD_DATA | streaming memory bytes out
    // WR_DATA | programming received bytes into the page
    // STAT    | streaming live status byte
    // ID      | streaming JEDEC id, then zeros
    // IGNORE  | swallowing bits until chip select rises
    typedef enum logic [2:0] {IDLE, CMD, ADDR, RD_DATA, WR_DATA, STAT, ID, IGNORE} state_t;

    localparam int BW = $clog2(BUSY_CYCLES + 1);

    state_t            state;
    logic [1:0]        sck_s, csn_s, mosi_s;
    logic              sck_d, csn_d;
    logic              sck_rise, sck_fall, csn_rise, csn_fall;
    logic [2:0]        bit_cnt;
    logic [6:0]        sh_in;
    logic [7:0]        rx_byte, op_q, tx_byte, tx_next, rd_q;
    logic [ADDR_W-1:0] addr, er_addr;
    logic [1:0]        addr_byte, id_idx;
    logic              addr_seen, exact8, pp_armed, erasing;
    logic [BW-1:0]     busy_cnt;

    logic [7:0]        mem [0:(2**ADDR_W)-1];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;

    assign sck_rise = sck_s[1] & ~sck_d;
    assign sck_fall = ~sck_s[1] & sck_d;
    assign csn_rise = csn_s[1] & ~csn_d;
    assign csn_fall = ~csn_s[1] & csn_d;
    assign rx_byte  = {sh_in, mosi_s[1]};

    always_comb begin
        tx_next = 8'h00;
        case (state)
            STAT:    tx_next = {6'b0, wel, wip};
            RD_DATA: tx_next = rd_q;
            ID: begin
                case (id_idx)
                    2'd0:    tx_next = JEDEC_ID[23:16];
                    2'd1:    tx_next = JEDEC_ID[15:8];
                    2'd2:    tx_next = JEDEC_ID[7:0];
                    default: tx_next = 8'h00;
                endcase
            end
            default: tx_next = 8'h00;
        endcase
    end

    // Program can only AND bits down; rd_q already holds mem[addr] for the RMW.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wdata = rd_q & rx_byte;
        if (erasing) begin
            mem_we    = rstn;
            mem_waddr = er_addr;
            mem_wdata = 8'hFF;
        end else if (state == WR_DATA && sck_rise && !csn_rise && !csn_fall && bit_cnt == 3'd7) begin
            mem_we = rstn;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk) begin
        rd_q <= mem[addr];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sck_s       <= 2'b00;
            csn_s       <= 2'b11;
            mosi_s      <= 2'b00;
            sck_d       <= 1'b0;
            csn_d       <= 1'b1;
            state       <= IDLE;
            bit_cnt     <= '0;
            sh_in       <= '0;
            op_q        <= '0;
            tx_byte     <= '0;
            addr        <= '0;
            er_addr     <= '0;
            addr_byte   <= '0;
            id_idx      <= '0;
            addr_seen   <= 1'b0;
            exact8      <= 1'b0;
            pp_armed    <= 1'b0;
            erasing     <= 1'b0;
            busy_cnt    <= '0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            wel         <= 1'b0;
            wip         <= 1'b0;
            last_cmd    <= '0;
        end else begin
            sck_s  <= {sck_s[0], spi_sck};
            csn_s  <= {csn_s[0], spi_csn};
            mosi_s <= {mosi_s[0], spi_mosi};
            sck_d  <= sck_s[1];
            csn_d  <= csn_s[1];

            if (csn_rise) begin
                state       <= IDLE;
                spi_miso    <= 1'b0;
                spi_miso_oe <= 1'b0;
                if (exact8) begin
                    case (op_q)
                        8'h06: wel <= 1'b1;
                        8'h04: wel <= 1'b0;
                        8'hC7: begin
                            erasing <= 1'b1;
                            wip     <= 1'b1;
                            er_addr <= '0;
                        end
                        default: ;
                    endcase
                end
                if (pp_armed && addr_seen) begin
                    wel      <= 1'b0;
                    wip      <= 1'b1;
                    busy_cnt <= BW'(BUSY_CYCLES - 1);
                end
            end else if (csn_fall) begin
                state     <= CMD;
                bit_cnt   <= '0;
                exact8    <= 1'b0;
                pp_armed  <= 1'b0;
                addr_seen <= 1'b0;
                addr_byte <= '0;
            end else if (state != IDLE && sck_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
                sh_in   <= rx_byte[6:0];
                exact8  <= 1'b0;
                case (state)
                    CMD: if (bit_cnt == 3'd7) begin
                        last_cmd <= rx_byte;
                        op_q     <= rx_byte;
                        state    <= IGNORE;
                        if (!wip || rx_byte == 8'h05) begin
                            case (rx_byte)
                                8'h05: state <= STAT;
                                8'h9F: begin
                                    state  <= ID;
                                    id_idx <= '0;
                                end
                                8'h03: state <= ADDR;
                                8'h02: if (wel) begin
                                    state    <= ADDR;
                                    pp_armed <= 1'b1;
                                end
                                8'h06, 8'h04: exact8 <= 1'b1;
                                8'hC7:        exact8 <= wel;
                                default: ;
                            endcase
                        end
                    end
                    ADDR: begin
                        addr      <= {addr[ADDR_W-2:0], mosi_s[1]};
                        addr_seen <= 1'b1;
                        if (bit_cnt == 3'd7) begin
                            addr_byte <= addr_byte + 2'd1;
                            if (addr_byte == 2'd2) state <= (op_q == 8'h03) ? RD_DATA : WR_DATA;
                        end
                    end
                    WR_DATA: if (bit_cnt == 3'd7) addr[7:0] <= addr[7:0] + 8'd1;
                    default: ;
                endcase
            end else if (sck_fall && (state == STAT || state == ID || state == RD_DATA)) begin
                if (bit_cnt == 3'd0) begin
                    tx_byte     <= tx_next;
                    spi_miso    <= tx_next[7];
                    spi_miso_oe <= 1'b1;
                    if (state == ID && id_idx != 2'd3) id_idx <= id_idx + 2'd1;
                    if (state == RD_DATA) addr <= addr + 1'b1;
                end else begin
                    spi_miso <= tx_byte[3'd7 - bit_cnt];
                end
            end

            if (erasing) begin
                er_addr <= er_addr + 1'b1;
                if (er_addr == '1) begin
                    erasing <= 1'b0;
                    wip     <= 1'b0;
                    wel     <= 1'b0;
                end
            end else if (wip) begin
                if (busy_cnt == '0) wip <= 1'b0;
                else                busy_cnt <= busy_cnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: acts as a mode-0 SPI master at clk/10.
module tb_spi_flash_responder;
    logic       clk = 1'b0;
    logic       rstn;
    logic       spi_sck, spi_csn, spi_mosi;
    logic       spi_miso, spi_miso_oe, wel, wip;
    logic [7:0] last_cmd;

    int checks = 0;
    int failures = 0;

    spi_flash_responder dut (
        .clk(clk), .rstn(rstn),
        .spi_sck(spi_sck), .spi_csn(spi_csn), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .wel(wel), .wip(wip), .last_cmd(last_cmd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Shifts out the n MSBs of tx; returns what the master sampled and how many bits had oe high.
    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx, output int oe_n);
        rx = 8'h00;
        oe_n = 0;
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = tx[i];
            #50;
            rx[i] = spi_miso;
            if (spi_miso_oe) oe_n++;
            spi_sck = 1'b1;
            #50;
            spi_sck = 1'b0;
        end
    endtask

    task automatic xb(input logic [7:0] tx, output logic [7:0] rx);
        int oe_n;
        spi_bits(tx, 8, rx, oe_n);
    endtask

    task automatic cs_begin();
        spi_csn = 1'b0;
        #100;
    endtask

    task automatic cs_end();
        #100;
        spi_csn = 1'b1;
        #100;
    endtask

    task automatic cmd_only(input logic [7:0] op);
        logic [7:0] r;
        cs_begin();
        xb(op, r);
        cs_end();
    endtask

    task automatic rdsr(output logic [7:0] st);
        logic [7:0] r;
        cs_begin();
        xb(8'h05, r);
        xb(8'h00, st);
        cs_end();
    endtask

    task automatic read2(input logic [23:0] a, output logic [7:0] r0, output logic [7:0] r1);
        logic [7:0] r;
        cs_begin();
        xb(8'h03, r);
        xb(a[23:16], r);
        xb(a[15:8], r);
        xb(a[7:0], r);
        xb(8'h00, r0);
        xb(8'h00, r1);
        cs_end();
    endtask

    initial begin
        logic [7:0] r, r0, r1;
        int oe_cmd, oe_data, oe_n, n, guard;

        rstn = 1'b0;
        spi_sck = 1'b0;
        spi_csn = 1'b1;
        spi_mosi = 1'b0;
        repeat (5) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("rst_miso", spi_miso, 1'b0);
        check("rst_oe", spi_miso_oe, 1'b0);
        check("rst_wel", wel, 1'b0);
        check("rst_wip", wip, 1'b0);
        check("rst_last_cmd", last_cmd, 8'h00);

        // RDID
        cs_begin();
        spi_bits(8'h9F, 8, r, oe_cmd);
        oe_data = 0;
        spi_bits(8'h00, 8, r, oe_n); oe_data += oe_n; check("rdid_b0", r, 8'hEF);
        spi_bits(8'h00, 8, r, oe_n); oe_data += oe_n; check("rdid_b1", r, 8'h40);
        spi_bits(8'h00, 8, r, oe_n); oe_data += oe_n; check("rdid_b2", r, 8'h16);
        spi_bits(8'h00, 8, r, oe_n); oe_data += oe_n; check("rdid_b3", r, 8'h00);
        check("rdid_oe_cmd", oe_cmd, 0);
        check("rdid_oe_data", oe_data, 32);
        cs_end();
        check("rdid_oe_after_cs", spi_miso_oe, 1'b0);

        // Status / write-enable latch
        rdsr(r); check("rdsr_reset", r, 8'h00);
        cmd_only(8'h06);
        rdsr(r); check("rdsr_wren", r, 8'h02);
        check("wel_pin_wren", wel, 1'b1);
        cmd_only(8'h04);
        rdsr(r); check("rdsr_wrdi", r, 8'h00);
        check("last_cmd_rdsr", last_cmd, 8'h05);

        // Chip erase with live polling
        cmd_only(8'h06);
        cmd_only(8'hC7);
        cs_begin();
        xb(8'h05, r);
        xb(8'h00, r);
        check("ce_poll_first", r, 8'h03);
        guard = 0;
        while (r != 8'h00 && guard < 60) begin
            xb(8'h00, r);
            guard++;
        end
        check("ce_poll_done", r, 8'h00);
        cs_end();
        check("ce_wel_cleared", wel, 1'b0);
        read2(24'h000010, r0, r1);
        check("ce_read0", r0, 8'hFF);
        check("ce_read1", r1, 8'hFF);

        // Program without WREN is ignored
        cs_begin();
        xb(8'h02, r); xb(8'h00, r); xb(8'h00, r); xb(8'h10, r); xb(8'hAA, r);
        cs_end();
        check("pp_nowren_wip", wip, 1'b0);
        read2(24'h000010, r0, r1);
        check("pp_nowren_read", r0, 8'hFF);

        // Program across page wrap, busy time
        cmd_only(8'h06);
        cs_begin();
        xb(8'h02, r); xb(8'h00, r); xb(8'h00, r); xb(8'hFF, r); xb(8'h12, r); xb(8'h34, r);
        #100;
        spi_csn = 1'b1;
        guard = 0;
        while (!wip && guard < 20) begin @(negedge clk); guard++; end
        n = 0;
        while (wip && n < 1000) begin n++; @(negedge clk); end
        check("pp_wip_cycles", n, 64);
        check("pp_wel_cleared", wel, 1'b0);
        read2(24'h0000FF, r0, r1);
        check("pp_read_ff", r0, 8'h12);
        read2(24'h000000, r0, r1);
        check("pp_read_wrap", r0, 8'h34);

        // Array wrap and ignored upper address bits
        read2(24'h0003FF, r0, r1);
        check("rd_arr_end", r0, 8'hFF);
        check("rd_arr_wrap", r1, 8'h34);
        read2(24'hABFC00, r0, r1);
        check("rd_upper_ignored", r0, 8'h34);

        // Partial WREN is discarded
        cs_begin();
        spi_bits(8'h06, 4, r, oe_n);
        cs_end();
        repeat (5) @(negedge clk);
        check("abort_wel", wel, 1'b0);
        check("abort_last_cmd", last_cmd, 8'h03);

        // Reset mid-erase
        cmd_only(8'h06);
        cmd_only(8'hC7);
        repeat (100) @(negedge clk);
        check("mid_ce_wip", wip, 1'b1);
        rstn = 1'b0;
        @(negedge clk);
        check("rst_mid_ce_wip", wip, 1'b0);
        check("rst_mid_ce_wel", wel, 1'b0);
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
